// File: rtl/clk_util_pkg.sv
// Shared types and constants for the clock-utility blocks: the monitor FSM state,
// default sizing, and the width rule for saturating counters.
package clk_util_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } mon_state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed by a counter that counts up to and holds at max_val.
    function automatic int sat_cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain plus history flop for an asynchronous level; emits registered
// one-cycle rise/fall strobes and the same detections one cycle early for local use.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              s_d;

    assign level = sync_q[STAGES-1];
    // rise/fall line up with the edge on which the registered strobes assert
    assign rise  = level & ~s_d;
    assign fall  = ~level & s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            s_d        <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], din};
            s_d        <= level;
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

endmodule

// File: rtl/slow_clk_monitor.sv
// Samples a slow clock as data: edge strobes, rise-to-rise period, loss detection.
// Define SLOW_CLK_MON_DUTY_EN to add the high_time output (high-phase length).
module slow_clk_monitor
    import clk_util_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_slow_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost
`ifdef SLOW_CLK_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam int                IDLE_W    = sat_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(TIMEOUT - 1);

    logic s, rise, fall, any_edge, timeout;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [IDLE_W-1:0] idle_cnt;

    mon_state_e       state, state_next;
    logic [CNT_W-1:0] period_next;
    logic             valid_next, lost_next;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .din        (clk_slow_in),
        .level      (s),
        .rise       (rise),
        .fall       (fall),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign any_edge = rise | fall;
    // idle reaches TIMEOUT on this edge; an edge in the same cycle always wins
    assign timeout  = !any_edge && (idle_cnt >= IDLE_TRIP);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idle_cnt <= '0;
        end else begin
            cnt <= rise ? '0 : cnt_inc;
            if (any_edge)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_LIM)
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        period_next = period;
        valid_next  = period_valid;
        lost_next   = lost;
        if (any_edge)
            lost_next = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            valid_next = 1'b0;
            lost_next  = 1'b1;
        end else if (rise) begin
            case (state)
                IDLE:  state_next = ARMED;
                ARMED, MEAS: begin
                    state_next  = MEAS;
                    period_next = cnt_inc;
                    valid_next  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state        <= state_next;
            period       <= period_next;
            period_valid <= valid_next;
            lost         <= lost_next;
        end
    end

`ifdef SLOW_CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt  <= '0;
            high_time <= '0;
        end else begin
            if (rise)
                high_cnt <= '0;
            else if (s && high_cnt != CNT_MAX)
                high_cnt <= high_cnt + CNT_W'(1);
            if (fall)
                high_time <= (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_level;
    assign unused_level = s;
`endif

endmodule
